// File: rtl/phase_acc_mp.sv
// Multi-profile DDS phase accumulator with shadow/active profile registers
// and an optional wrap-synchronous profile switch.
module phase_acc_mp #(
  parameter int ACC_W       = 28,
  parameter int PHASE_W     = 12,
  parameter int NPROF       = 4,
  parameter int SYNC_SWITCH = 1,
  localparam int AW         = $clog2(NPROF)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               sync_clr,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic               wr_reg,
  input  logic [ACC_W-1:0]   wr_data,
  input  logic               update,
  input  logic [AW-1:0]      prof_sel,
  output logic [AW-1:0]      prof_cur,
  output logic               switch_pend,
  output logic               wrap,
  output logic [PHASE_W-1:0] phase_out
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [AW:0] NPROF_V = (AW+1)'(NPROF);

  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     sum;
  logic               carry;
  logic               wr_ok;
  logic               sel_ok;
  logic               req;

  logic [ACC_W-1:0]   ftw_sh   [NPROF];
  logic [ACC_W-1:0]   ftw_act  [NPROF];
  logic [PHASE_W-1:0] pofs_sh  [NPROF];
  logic [PHASE_W-1:0] pofs_act [NPROF];

  state_t             state;
  state_t             state_nx;
  logic [AW-1:0]      target;
  logic [AW-1:0]      target_nx;
  logic [AW-1:0]      cur_nx;

  assign sum    = {1'b0, acc} + {1'b0, ftw_act[prof_cur]};
  assign carry  = run & ~sync_clr & sum[ACC_W];
  assign wr_ok  = wr_en & ({1'b0, wr_addr} < NPROF_V);
  assign sel_ok = {1'b0, prof_sel} < NPROF_V;
  assign req    = sel_ok & (prof_sel != prof_cur);

  assign switch_pend = (state == WAIT);

  // Commit samples the shadow before this edge's write lands
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPROF; i++) begin
        ftw_sh[i]   <= '0;
        ftw_act[i]  <= '0;
        pofs_sh[i]  <= '0;
        pofs_act[i] <= '0;
      end
    end else begin
      if (update) begin
        for (int i = 0; i < NPROF; i++) begin
          ftw_act[i]  <= ftw_sh[i];
          pofs_act[i] <= pofs_sh[i];
        end
      end
      if (wr_ok) begin
        if (wr_reg) begin
          pofs_sh[wr_addr] <= wr_data[PHASE_W-1:0];
        end else begin
          ftw_sh[wr_addr] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      wrap      <= 1'b0;
      phase_out <= '0;
    end else begin
      phase_out <= acc[ACC_W-1 -: PHASE_W] + pofs_act[prof_cur];
      if (sync_clr) begin
        acc  <= '0;
        wrap <= 1'b0;
      end else if (run) begin
        acc  <= sum[ACC_W-1:0];
        wrap <= sum[ACC_W];
      end else begin
        wrap <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      target   <= '0;
      prof_cur <= '0;
    end else begin
      state    <= state_nx;
      target   <= target_nx;
      prof_cur <= cur_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target;
    cur_nx    = prof_cur;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (SYNC_SWITCH == 0) begin
            cur_nx = prof_sel;
          end else begin
            target_nx = prof_sel;
            state_nx  = WAIT;
          end
        end
      end
      WAIT: begin
        if (sync_clr || carry) begin
          cur_nx   = target;
          state_nx = IDLE;
        end else if (prof_sel == prof_cur) begin
          state_nx = IDLE;
        end else if (sel_ok) begin
          target_nx = prof_sel;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_phase_acc_mp.sv
// Bench for phase_acc_mp: arithmetic reference model checked every cycle
// plus hand-computed literal expectations for the directed scenarios.
module tb_phase_acc_mp;

  localparam int ACC_W   = 28;
  localparam int PHASE_W = 12;
  localparam int NPROF   = 3;
  localparam int AW      = 2;
  localparam longint MOD = 64'd1 << ACC_W;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               run = 1'b0;
  logic               sync_clr = 1'b0;
  logic               wr_en = 1'b0;
  logic [AW-1:0]      wr_addr = '0;
  logic               wr_reg = 1'b0;
  logic [ACC_W-1:0]   wr_data = '0;
  logic               update = 1'b0;
  logic [AW-1:0]      prof_sel = '0;

  logic [AW-1:0]      prof_cur;
  logic               switch_pend;
  logic               wrap;
  logic [PHASE_W-1:0] phase_out;
  logic [AW-1:0]      b_prof_cur;
  logic               b_pend;
  logic               b_wrap;
  logic [PHASE_W-1:0] b_phase;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  phase_acc_mp #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .NPROF(NPROF),
                 .SYNC_SWITCH(1)) dut (
    .clock(clock), .reset(reset), .run(run), .sync_clr(sync_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_reg(wr_reg), .wr_data(wr_data),
    .update(update), .prof_sel(prof_sel), .prof_cur(prof_cur),
    .switch_pend(switch_pend), .wrap(wrap), .phase_out(phase_out)
  );

  phase_acc_mp #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .NPROF(NPROF),
                 .SYNC_SWITCH(0)) dut0 (
    .clock(clock), .reset(reset), .run(run), .sync_clr(sync_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_reg(wr_reg), .wr_data(wr_data),
    .update(update), .prof_sel(prof_sel), .prof_cur(b_prof_cur),
    .switch_pend(b_pend), .wrap(b_wrap), .phase_out(b_phase)
  );

  always #5 clock = ~clock;

  // reference model state
  longint m_acc;
  longint m_ftw_sh [NPROF];
  longint m_ftw_act[NPROF];
  longint m_pofs_sh [NPROF];
  longint m_pofs_act[NPROF];
  int     m_cur, m_tgt, m0_cur;
  bit     m_pend, m_wrap;
  longint m_phase;

  task automatic check(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_acc = 0; m_cur = 0; m_tgt = 0; m0_cur = 0;
    m_pend = 0; m_wrap = 0; m_phase = 0;
    for (int i = 0; i < NPROF; i++) begin
      m_ftw_sh[i] = 0; m_ftw_act[i] = 0;
      m_pofs_sh[i] = 0; m_pofs_act[i] = 0;
    end
  endtask

  task automatic m_step();
    longint s;
    bit c;
    bit ok;
    int sel;
    sel = int'(prof_sel);
    ok  = sel < NPROF;
    s   = m_acc + m_ftw_act[m_cur];
    c   = run && !sync_clr && (s >= MOD);
    m_phase = (m_acc / 65536 + m_pofs_act[m_cur]) % 4096;
    if (!m_pend) begin
      if (ok && sel != m_cur) begin
        m_tgt = sel;
        m_pend = 1;
      end
    end else if (sync_clr || c) begin
      m_cur = m_tgt;
      m_pend = 0;
    end else if (sel == m_cur) begin
      m_pend = 0;
    end else if (ok) begin
      m_tgt = sel;
    end
    if (ok) m0_cur = sel;
    if (sync_clr) begin
      m_acc = 0; m_wrap = 0;
    end else if (run) begin
      m_acc = s % MOD; m_wrap = c;
    end else begin
      m_wrap = 0;
    end
    if (update) begin
      for (int i = 0; i < NPROF; i++) begin
        m_ftw_act[i] = m_ftw_sh[i];
        m_pofs_act[i] = m_pofs_sh[i];
      end
    end
    if (wr_en && int'(wr_addr) < NPROF) begin
      if (wr_reg) m_pofs_sh[wr_addr] = longint'(wr_data) % 4096;
      else m_ftw_sh[wr_addr] = longint'(wr_data);
    end
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) m_clear();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        check("m_prof_cur", longint'(prof_cur), longint'(m_cur));
        check("m_pend", longint'(switch_pend), longint'(m_pend));
        check("m_wrap", longint'(wrap), longint'(m_wrap));
        check("m_phase", longint'(phase_out), m_phase);
        check("m_acc", longint'(dut.acc), m_acc);
        check("m_prof_cur_imm", longint'(b_prof_cur), longint'(m0_cur));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input bit r, input longint d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_reg = r;
    wr_data = ACC_W'(d);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_phase", longint'(phase_out), 0);
    check("rst_wrap", longint'(wrap), 0);
    check("rst_pend", longint'(switch_pend), 0);
    check("rst_cur", longint'(prof_cur), 0);
    reset = 1'b1;
    chk_en = 1'b1;

    // T1: 1000 increments of 0xA7C6
    wr(0, 0, 'hA7C6);
    update = 1'b1; tick(); update = 1'b0;
    run = 1'b1;
    repeat (1000) tick();
    run = 1'b0;
    check("t1_acc", longint'(dut.acc), 42950000);
    tick();
    check("t1_phase", longint'(phase_out), 655);

    // T2: half-scale FTW
    wr(0, 0, 'h800_0000);
    update = 1'b1; sync_clr = 1'b1; tick();
    update = 1'b0; sync_clr = 1'b0;
    run = 1'b1;
    tick();
    tick();
    check("t2_wrap1", longint'(wrap), 1);
    check("t2_phase1", longint'(phase_out), 'h800);
    tick();
    check("t2_wrap0", longint'(wrap), 0);
    check("t2_phase0", longint'(phase_out), 0);
    run = 1'b0;

    // T3: deferred switch completes on wrap
    wr(0, 0, 'h400_0000);
    wr(1, 0, 'h800_0000);
    update = 1'b1; sync_clr = 1'b1; tick();
    update = 1'b0; sync_clr = 1'b0;
    run = 1'b1;
    tick();
    prof_sel = 2'd1;
    tick();
    check("t3_pend_a", longint'(switch_pend), 1);
    check("t3_cur_a", longint'(prof_cur), 0);
    check("t3_cur_imm", longint'(b_prof_cur), 1);
    tick();
    check("t3_pend_b", longint'(switch_pend), 1);
    tick();
    check("t3_wrap", longint'(wrap), 1);
    check("t3_cur_b", longint'(prof_cur), 1);
    check("t3_pend_c", longint'(switch_pend), 0);
    tick();
    check("t3_acc_step", longint'(dut.acc), 'h800_0000);
    tick();
    check("t3_wrap2", longint'(wrap), 1);
    run = 1'b0;

    // T4: shadow isolation and commit ordering
    prof_sel = 2'd0;
    tick();
    sync_clr = 1'b1; tick(); sync_clr = 1'b0;
    check("t4_cur", longint'(prof_cur), 0);
    wr(0, 0, 'h1000);
    run = 1'b1; tick(); run = 1'b0;
    check("t4_noupd", longint'(dut.acc), 'h400_0000);
    update = 1'b1; tick(); update = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    check("t4_upd", longint'(dut.acc), 'h400_1000);
    wr_en = 1'b1; wr_addr = 2'd0; wr_reg = 1'b0; wr_data = 'h2000;
    update = 1'b1; tick();
    wr_en = 1'b0; update = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    check("t4_oldshadow", longint'(dut.acc), 'h400_2000);
    update = 1'b1; tick(); update = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    check("t4_newshadow", longint'(dut.acc), 'h400_4000);

    // T5: offset with zero FTW, ignored writes, pending switch
    wr(0, 0, 0);
    wr(0, 1, 'h400);
    wr(3, 0, 'hFFFF);
    update = 1'b1; sync_clr = 1'b1; tick();
    update = 1'b0; sync_clr = 1'b0;
    tick();
    check("t5_phase", longint'(phase_out), 'h400);
    run = 1'b1;
    repeat (5) tick();
    check("t5_static", longint'(dut.acc), 0);
    prof_sel = 2'd3;
    tick();
    check("t5_badsel", longint'(switch_pend), 0);
    check("t5_badsel_imm", longint'(b_prof_cur), 0);
    prof_sel = 2'd1;
    repeat (10) tick();
    check("t5_pending", longint'(switch_pend), 1);
    check("t5_cur_hold", longint'(prof_cur), 0);
    sync_clr = 1'b1; tick(); sync_clr = 1'b0;
    check("t5_clr_pend", longint'(switch_pend), 0);
    check("t5_clr_cur", longint'(prof_cur), 1);

    // T6: asynchronous reset mid-run
    repeat (2) tick();
    #2;
    reset = 1'b0;
    #1;
    check("t6_phase", longint'(phase_out), 0);
    check("t6_wrap", longint'(wrap), 0);
    check("t6_cur", longint'(prof_cur), 0);
    check("t6_pend", longint'(switch_pend), 0);
    check("t6_acc", longint'(dut.acc), 0);
    check("t6_cur_imm", longint'(b_prof_cur), 0);
    tick();
    reset = 1'b1;
    prof_sel = 2'd0;
    repeat (5) tick();
    check("t6_restart", longint'(dut.acc), 0);
    check("t6_nowrap", longint'(wrap), 0);
    run = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
